// File: rtl/tpu_pkg.sv
// Shared types, sizes and the fixed scratch-memory contents for the TPU slice.
package tpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ACC_W    = 32;
    localparam int UB_DEPTH = 64;
    localparam int SM_DEPTH = 32;
    localparam int RUN_LEN  = 5;    // compute run occupies t = 0..RUN_LEN-1
    localparam int INSTR_W  = 16;
    localparam int ADDR_W   = 13;
    localparam int SM_AW    = $clog2(SM_DEPTH);
    localparam int UB_AW    = $clog2(UB_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP         = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUT  = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_STORE       = 3'b101
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Weight scratch memory: read-only, zero except a 2x2 tile at 15..18.
    function automatic logic [DATA_W-1:0] weight_rom(input logic [SM_AW-1:0] idx);
        case (idx)
            5'd15:   return 8'd1;
            5'd16:   return 8'd2;
            5'd17:   return 8'd3;
            5'd18:   return 8'd4;
            default: return '0;
        endcase
    endfunction

    // Input scratch memory: read-only, tile straddles the wrap point 30,31,0,1.
    function automatic logic [DATA_W-1:0] input_rom(input logic [SM_AW-1:0] idx);
        case (idx)
            5'd30:   return 8'd5;
            5'd31:   return 8'd6;
            5'd0:    return 8'd7;
            5'd1:    return 8'd8;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/tpu_if.sv
// Sequencer-facing bundle: instruction stream in, unified buffer out, plus
// debug visibility of the compute controller.
// There is no handshake: one instruction is consumed on every rising clk
// edge, and unified_mem is always valid (it is the registered buffer).
interface tpu_if;
    import tpu_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [ACC_W-1:0]   unified_mem [0:UB_DEPTH-1];
    run_state_e         dbg_state;
    logic               dbg_done;

    modport master (output instruction, input unified_mem, input dbg_state, input dbg_done);
    modport slave  (input instruction, output unified_mem, output dbg_state, output dbg_done);
endinterface

// File: rtl/tpu_pe.sv
// One output-stationary MAC cell: accumulates a*b and forwards a right, b down.
module tpu_pe
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [ACC_W-1:0]    acc_q;
    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

    // Operand pass-through and wrapping accumulation; clear starts a fresh run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clear_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/tpu_main.sv
// TPU top: instruction decode, operand tiles, 2x2 systolic array, unified buffer.
module tpu_main
    import tpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    tpu_if.slave bus
);
    opcode_e             op;
    logic [ADDR_W-1:0]   operand;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   w_q [0:1][0:1];
    logic [DATA_W-1:0]   x_q [0:1][0:1];
    logic [ACC_W-1:0]    res_q [0:3];
    logic [ACC_W-1:0]    ub_q [0:UB_DEPTH-1];
    logic                prev_compute_q;
    run_state_e          state_q, state_d;
    logic [2:0]          t_q, t_d;
    logic                done_q, done_d;
    logic                start, finish, run;
    logic [2:0]          k_v;
    logic [DATA_W-1:0]   a_in [0:1];
    logic [DATA_W-1:0]   b_in [0:1];
    logic [DATA_W-1:0]   a_out [0:1][0:1];
    logic [DATA_W-1:0]   b_out [0:1][0:1];
    logic [ACC_W-1:0]    acc [0:1][0:1];
    logic                unused_bits;

    assign op      = opcode_e'(bus.instruction[15:13]);
    assign operand = bus.instruction[12:0];

    // Run controller: a COMPUTE edge while idle starts a self-timed run of RUN_LEN cycles.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = done_q;
        start   = 1'b0;
        finish  = 1'b0;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op == OP_COMPUTE && !prev_compute_q) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                    t_d     = '0;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                run = 1'b1;
                if (t_q == 3'(RUN_LEN - 1)) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers and COMPUTE edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            t_q            <= '0;
            done_q         <= 1'b0;
            prev_compute_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            done_q         <= done_d;
            prev_compute_q <= (op == OP_COMPUTE);
        end
    end

    // Skewed edge injection: row/column i carries operand k = t - i while k is 0 or 1.
    always_comb begin
        k_v = '0;
        for (int i = 0; i < 2; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
            if (run && t_q >= 3'(i) && (t_q - 3'(i)) < 3'd2) begin
                k_v     = t_q - 3'(i);
                a_in[i] = w_q[i][k_v[0]];
                b_in[i] = x_q[k_v[0]][i];
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_row
        for (genvar j = 0; j < 2; j++) begin : g_col
            logic [DATA_W-1:0] a_src, b_src;
            if (j == 0) begin : g_a_edge
                assign a_src = a_in[i];
            end else begin : g_a_chain
                assign a_src = a_out[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src = b_in[j];
            end else begin : g_b_chain
                assign b_src = b_out[i-1][j];
            end
            tpu_pe u_pe (
                .clk     (clk),
                .reset   (reset),
                .clear_i (start),
                .a_i     (a_src),
                .b_i     (b_src),
                .a_o     (a_out[i][j]),
                .b_o     (b_out[i][j]),
                .acc_o   (acc[i][j])
            );
        end
    end

    // Datapath: address/tile loads, result capture at run end, STORE into the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    w_q[r][c] <= '0;
                    x_q[r][c] <= '0;
                end
            end
            for (int n = 0; n < 4; n++) res_q[n] <= '0;
            for (int u = 0; u < UB_DEPTH; u++) ub_q[u] <= '0;
        end else begin
            case (op)
                OP_LOAD_ADDR: addr_q <= operand;
                OP_LOAD_WEIGHT: begin
                    for (int r = 0; r < 2; r++)
                        for (int c = 0; c < 2; c++)
                            w_q[r][c] <= weight_rom(addr_q[SM_AW-1:0] + SM_AW'(2*r + c));
                end
                OP_LOAD_INPUT: begin
                    for (int r = 0; r < 2; r++)
                        for (int c = 0; c < 2; c++)
                            x_q[r][c] <= input_rom(addr_q[SM_AW-1:0] + SM_AW'(2*r + c));
                end
                OP_STORE: begin
                    if (done_q) begin
                        for (int n = 0; n < 4; n++)
                            ub_q[addr_q[UB_AW-1:0] + UB_AW'(n)] <= res_q[n];
                    end
                end
                default: ;
            endcase
            if (finish) begin
                res_q[0] <= acc[0][0];
                res_q[1] <= acc[0][1];
                res_q[2] <= acc[1][0];
                res_q[3] <= acc[1][1];
            end
        end
    end

    for (genvar u = 0; u < UB_DEPTH; u++) begin : g_ub_out
        assign bus.unified_mem[u] = ub_q[u];
    end

    assign bus.dbg_state = state_q;
    assign bus.dbg_done  = done_q;

    // Operands leaving the array edge and high address bits have no consumer.
    assign unused_bits = ^{a_out[0][1], a_out[1][1], b_out[1][0], b_out[1][1],
                           addr_q[ADDR_W-1:UB_AW]};
endmodule

// File: tb/tb_tpu_main.sv
// Bench for tpu_main: matrix-level reference model, per-cycle compare, literal pins.
module tb_tpu_main;
  import tpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tpu_if bus();
  tpu_main dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  logic [ACC_W-1:0] exp_q[$];

  // reference model state
  int          wrom [SM_DEPTH];
  int          xrom [SM_DEPTH];
  int          m_addr;
  int          m_w [4];
  int          m_x [4];
  bit          m_busy;
  int          m_remain;
  bit          m_done;
  bit          m_prev_c;
  logic [31:0] m_pend [4];
  logic [31:0] m_res [4];
  logic [31:0] m_ub [UB_DEPTH];

  task automatic model_reset();
    for (int i = 0; i < SM_DEPTH; i++) begin
      wrom[i] = 0;
      xrom[i] = 0;
    end
    wrom[15] = 1; wrom[16] = 2; wrom[17] = 3; wrom[18] = 4;
    xrom[30] = 5; xrom[31] = 6; xrom[0] = 7; xrom[1] = 8;
    m_addr = 0; m_busy = 0; m_remain = 0; m_done = 0; m_prev_c = 0;
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 0; m_x[i] = 0; m_pend[i] = '0; m_res[i] = '0;
    end
    for (int u = 0; u < UB_DEPTH; u++) m_ub[u] = '0;
  endtask

  // Effect of one instruction at a clock edge, from the instruction-level rules.
  task automatic model_step(input logic [15:0] ins);
    int op;
    int opd;
    bit is_c;
    bit starts;
    logic [31:0] s;
    op = int'(ins[15:13]);
    opd = int'(ins[12:0]);
    is_c = (op == 4);
    starts = is_c && !m_prev_c && !m_busy;
    if (op == 5 && m_done)
      for (int n = 0; n < 4; n++) m_ub[(m_addr % 64 + n) % 64] = m_res[n];
    if (m_busy) begin
      m_remain--;
      if (m_remain == 0) begin
        m_busy = 0;
        m_done = 1;
        for (int n = 0; n < 4; n++) m_res[n] = m_pend[n];
      end
    end
    if (starts) begin
      m_busy = 1;
      m_remain = RUN_LEN;
      m_done = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          s = '0;
          for (int k = 0; k < 2; k++) s = s + 32'(m_w[2*i+k] * m_x[2*k+j]);
          m_pend[2*i+j] = s;
        end
    end
    if (op == 1) m_addr = opd;
    if (op == 2)
      for (int e = 0; e < 4; e++) m_w[e] = wrom[(m_addr + e) % 32];
    if (op == 3)
      for (int e = 0; e < 4; e++) m_x[e] = xrom[(m_addr + e) % 32];
    m_prev_c = is_c;
  endtask

  // The single compare point: buffer contents and done flag against the model.
  task automatic compare_cycle();
    int bad;
    bad = -1;
    for (int u = 0; u < UB_DEPTH; u++)
      if (bad < 0 && bus.unified_mem[u] !== m_ub[u]) bad = u;
    n_checks++;
    if (bad < 0) n_pass++;
    else $display("FAIL ub_cycle t=%0t idx=%0d got=%0d want=%0d", $time, bad,
                  bus.unified_mem[bad], m_ub[bad]);
    n_checks++;
    if (bus.dbg_done === m_done) n_pass++;
    else $display("FAIL done_flag t=%0t got=%b want=%b", $time, bus.dbg_done, m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step(bus.instruction);
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic drive(input logic [2:0] op, input logic [12:0] opd, input int n);
    bus.instruction = {op, opd};
    repeat (n) cycle();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus.instruction = '0;
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  // Hand-computed expectations for four consecutive buffer words.
  task automatic check_lit(input string name, input int base, input logic [31:0] v0,
                           input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] e;
    int idx;
    exp_q.push_back(v0); exp_q.push_back(v1); exp_q.push_back(v2); exp_q.push_back(v3);
    for (int n = 0; n < 4; n++) begin
      e = exp_q.pop_front();
      idx = (base + n) % 64;
      n_checks++;
      if (bus.unified_mem[idx] === e) n_pass++;
      else $display("FAIL %s dut[%0d] got=%0d want=%0d", name, idx, bus.unified_mem[idx], e);
      n_checks++;
      if (m_ub[idx] === e) n_pass++;
      else $display("FAIL %s model[%0d] got=%0d want=%0d", name, idx, m_ub[idx], e);
    end
  endtask

  task automatic run_program(input logic [12:0] store_addr, input int hold);
    drive(3'b001, 13'd15, 1);
    drive(3'b010, 13'd0, 2);
    drive(3'b001, 13'd30, 1);
    drive(3'b011, 13'd0, 1);
    drive(3'b100, 13'd0, hold);
    drive(3'b001, store_addr, 1);
    drive(3'b101, 13'd0, 2);
    drive(3'b000, 13'd0, 1);
  endtask

  initial begin
    int op;
    int opd;
    int addr_pick [8];
    addr_pick = '{15, 16, 30, 31, 0, 1, 62, 7};
    reset = 1'b1;
    bus.instruction = '0;
    model_reset();
    @(negedge clk);
    cycle();
    reset = 1'b0;

    // reset state, STORE without a prior COMPUTE
    check_lit("reset_zero", 0, 0, 0, 0, 0);
    drive(3'b101, 13'd0, 2);
    check_lit("store_no_done", 0, 0, 0, 0, 0);

    // full program
    pulse_reset();
    run_program(13'd7, 7);
    check_lit("full_prog", 7, 19, 22, 43, 50);
    check_lit("full_prog_below", 3, 0, 0, 0, 0);
    check_lit("full_prog_above", 11, 0, 0, 0, 0);

    // STORE wrap
    pulse_reset();
    run_program(13'd62, 7);
    check_lit("store_wrap", 62, 19, 22, 43, 50);

    // held COMPUTE, then recompute after a NOP
    pulse_reset();
    run_program(13'd7, 12);
    check_lit("held_compute", 7, 19, 22, 43, 50);
    drive(3'b100, 13'd0, 7);
    drive(3'b001, 13'd20, 1);
    drive(3'b101, 13'd0, 1);
    check_lit("recompute", 20, 19, 22, 43, 50);

    // STORE mid-run is ignored, STORE after completion lands
    pulse_reset();
    drive(3'b001, 13'd15, 1);
    drive(3'b010, 13'd0, 1);
    drive(3'b001, 13'd30, 1);
    drive(3'b011, 13'd0, 1);
    drive(3'b100, 13'd0, 2);
    drive(3'b101, 13'd0, 1);
    check_lit("store_mid_run", 30, 0, 0, 0, 0);
    drive(3'b000, 13'd0, 4);
    drive(3'b101, 13'd0, 1);
    check_lit("store_after_run", 30, 19, 22, 43, 50);

    // reset in the middle of a run
    pulse_reset();
    drive(3'b001, 13'd15, 1);
    drive(3'b010, 13'd0, 1);
    drive(3'b001, 13'd30, 1);
    drive(3'b011, 13'd0, 1);
    drive(3'b100, 13'd0, 3);
    pulse_reset();
    drive(3'b000, 13'd0, 6);
    drive(3'b101, 13'd0, 1);
    check_lit("reset_mid_run", 30, 0, 0, 0, 0);
    check_lit("reset_mid_run_lo", 0, 0, 0, 0, 0);

    // randomized instruction stream
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 7);
      if (m_busy && (op == 2 || op == 3)) op = 0;
      if (op == 1) begin
        if ($urandom_range(0, 3) == 0) opd = $urandom_range(0, 8191);
        else opd = addr_pick[$urandom_range(0, 7)];
      end else begin
        opd = $urandom_range(0, 8191);
      end
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else drive(3'(op), 13'(opd), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
